uart_pkt_ctrl: RTL and testbench

UART_PKT_CTRL -- requirements
Module: uart_pkt_ctrl

---
 rtl/uart_pkt_ctrl_if.sv | 24 ++
 rtl/uart_pkt_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_uart_pkt_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_ctrl_if.sv
// Byte-stream input, register-write handshake and packet status bundle for uart_pkt_ctrl.
// The master modport is the controller side; slave is the UART/register-target side.
interface uart_pkt_ctrl_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Wr_En;
  logic       i_Wr_Rdy;
  logic [7:0] o_Wr_Addr;
  logic [7:0] o_Wr_Data;
  logic       o_Pkt_Done;
  logic       o_Pkt_Err;
  logic [1:0] o_Err_Code;
  logic       o_Busy;

  modport master (
    input  i_Rx_DV, i_Rx_Byte, i_Wr_Rdy,
    output o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Pkt_Done, o_Pkt_Err, o_Err_Code, o_Busy
  );

  modport slave (
    output i_Rx_DV, i_Rx_Byte, i_Wr_Rdy,
    input  o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Pkt_Done, o_Pkt_Err, o_Err_Code, o_Busy
  );
endinterface

// File: rtl/uart_pkt_ctrl.sv
// UART packet parser: A5/ADDR/LEN/payload[/CHK] frames are buffered, validated, then drained
// as register writes. Define UART_PKT_CHKSUM_EN to enable the trailing checksum byte.
module uart_pkt_ctrl #(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 8700
) (
  input  logic            i_Clock,
  input  logic            i_Rst_L,
  uart_pkt_ctrl_if.master bus
);

  localparam int unsigned IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned Depth   = 1 << IdxW;
  localparam logic [7:0]  MaxLen  = 8'(MAX_LEN);
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CLKS - 2);
  localparam logic [7:0]  Header  = 8'hA5;

  localparam logic [1:0] ErrTimeout = 2'b00;
  localparam logic [1:0] ErrLen     = 2'b01;
  localparam logic [1:0] ErrOverrun = 2'b11;

`ifdef UART_PKT_CHKSUM_EN
  localparam logic [1:0] ErrChk     = 2'b10;
  typedef enum logic [2:0] {StIdle, StAddr, StLen, StPayload, StChk, StDrain} state_e;
`else
  typedef enum logic [2:0] {StIdle, StAddr, StLen, StPayload, StDrain} state_e;
`endif

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic        ovr_pend_q, ovr_pend_d;
`ifdef UART_PKT_CHKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        busy_q, busy_d;

  logic [7:0]  buf_q [Depth];

  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        wr_fire;
  logic        counting;
  logic        timeout_hit;
  logic        buf_we;
  logic        start_drain;
  logic        last_write;
  logic        err_fire;
  logic [1:0]  err_code;
  logic        overrun;
  logic [7:0]  first_data;

  assign rx_dv   = bus.i_Rx_DV;
  assign rx_byte = bus.i_Rx_Byte;
  assign wr_fire = wr_en_q & bus.i_Wr_Rdy;

  // State register plus all registered datapath and outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      ovr_pend_q <= 1'b0;
`ifdef UART_PKT_CHKSUM_EN
      sum_q      <= '0;
`endif
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      ovr_pend_q <= ovr_pend_d;
`ifdef UART_PKT_CHKSUM_EN
      sum_q      <= sum_d;
`endif
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      busy_q     <= busy_d;
    end
  end

  // Payload storage has no reset; contents are don't-care outside a packet.
  always_ff @(posedge i_Clock) begin
    if (buf_we) begin
      buf_q[idx_q[IdxW-1:0]] <= rx_byte;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
`ifdef UART_PKT_CHKSUM_EN
    sum_d       = sum_q;
`endif
    buf_we      = 1'b0;
    start_drain = 1'b0;
    last_write  = 1'b0;
    err_fire    = 1'b0;
    err_code    = ErrTimeout;

    counting    = (state_q != StIdle) && (state_q != StDrain);
    timeout_hit = counting && !rx_dv && (tmo_q == TmoLast);

    unique case (state_q)
      StIdle: begin
        if (rx_dv && (rx_byte == Header)) begin
          state_d = StAddr;
`ifdef UART_PKT_CHKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StAddr: begin
        if (rx_dv) begin
          addr_d  = rx_byte;
          state_d = StLen;
`ifdef UART_PKT_CHKSUM_EN
          sum_d   = sum_q + rx_byte;
`endif
        end
      end
      StLen: begin
        if (rx_dv) begin
          if ((rx_byte == 8'd0) || (rx_byte > MaxLen)) begin
            err_fire = 1'b1;
            err_code = ErrLen;
            state_d  = StIdle;
          end else begin
            len_d   = rx_byte;
            idx_d   = '0;
            state_d = StPayload;
`ifdef UART_PKT_CHKSUM_EN
            sum_d   = sum_q + rx_byte;
`endif
          end
        end
      end
      StPayload: begin
        if (rx_dv) begin
          buf_we = 1'b1;
`ifdef UART_PKT_CHKSUM_EN
          sum_d  = sum_q + rx_byte;
`endif
          if (idx_q == len_q - 8'd1) begin
`ifdef UART_PKT_CHKSUM_EN
            state_d     = StChk;
`else
            state_d     = StDrain;
            idx_d       = '0;
            start_drain = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
`ifdef UART_PKT_CHKSUM_EN
      StChk: begin
        if (rx_dv) begin
          if (rx_byte == sum_q) begin
            state_d     = StDrain;
            idx_d       = '0;
            start_drain = 1'b1;
          end else begin
            err_fire = 1'b1;
            err_code = ErrChk;
            state_d  = StIdle;
          end
        end
      end
`endif
      StDrain: begin
        if (wr_fire) begin
          if (idx_q == len_q - 8'd1) begin
            last_write = 1'b1;
            idx_d      = '0;
            state_d    = StIdle;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A received byte always wins over a timeout on the same cycle.
    if (timeout_hit) begin
      err_fire = 1'b1;
      err_code = ErrTimeout;
      state_d  = StIdle;
    end

    if (rx_dv || !counting || (state_d == StIdle)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_comb begin
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = last_write;
    err_d      = 1'b0;
    code_d     = code_q;
    ovr_pend_d = 1'b0;
    busy_d     = (state_d != StIdle);
    overrun    = (state_q == StDrain) && rx_dv;

    // With LEN=1 and no checksum stage the only byte is still on the bus.
    first_data = ((state_q == StPayload) && (idx_q == 8'd0)) ? rx_byte : buf_q[0];

    if (start_drain) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = first_data;
    end else if (last_write) begin
      wr_en_d = 1'b0;
    end else if (wr_fire) begin
      wr_addr_d = addr_q + idx_d;
      wr_data_d = buf_q[idx_d[IdxW-1:0]];
    end

    if (err_fire) begin
      err_d  = 1'b1;
      code_d = err_code;
    end

    // An overrun on the final handshake is reported one cycle after the done pulse.
    if (overrun) begin
      if (last_write) begin
        ovr_pend_d = 1'b1;
      end else begin
        err_d  = 1'b1;
        code_d = ErrOverrun;
      end
    end

    if (ovr_pend_q) begin
      err_d  = 1'b1;
      code_d = ErrOverrun;
    end
  end

  assign bus.o_Wr_En    = wr_en_q;
  assign bus.o_Wr_Addr  = wr_addr_q;
  assign bus.o_Wr_Data  = wr_data_q;
  assign bus.o_Pkt_Done = done_q;
  assign bus.o_Pkt_Err  = err_q;
  assign bus.o_Err_Code = code_q;
  assign bus.o_Busy     = busy_q;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed bench for uart_pkt_ctrl: frame table plus stall, overrun, reset and timeout sequences.
// Builds with or without UART_PKT_CHKSUM_EN.
module tb_uart_pkt_ctrl;

  logic i_Clock;
  logic i_Rst_L;

  uart_pkt_ctrl_if bus ();

  uart_pkt_ctrl #(
    .MAX_LEN      (16),
    .TIMEOUT_CLKS (8700)
  ) dut (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .bus     (bus)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic [63:0] bytes;   // first byte in [63:56]
    int          n;
    int          nwr;
    logic [47:0] wr;      // {a0,d0,a1,d1,a2,d2}
    int          ndone;
    int          nerr;
    logic [1:0]  code;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_dv_cyc = 0;
  int          done_n = 0;
  int          err_n = 0;
  int          both_n = 0;
  logic [1:0]  last_code = 2'b00;
  logic [31:0] wr_log [$];

  always @(posedge i_Clock) cyc <= cyc + 1;

  always @(negedge i_Clock) begin
    if (bus.o_Wr_En && bus.i_Wr_Rdy) wr_log.push_back({cyc[15:0], bus.o_Wr_Addr, bus.o_Wr_Data});
    if (bus.o_Pkt_Done) done_n++;
    if (bus.o_Pkt_Err) begin
      err_n++;
      last_code = bus.o_Err_Code;
    end
    if (bus.o_Pkt_Done && bus.o_Pkt_Err) both_n++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller sits just after a rising edge; the byte is consumed at the next one.
  task automatic send_byte(input logic [7:0] b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    last_dv_cyc   = cyc;
    @(posedge i_Clock);
    #1;
    bus.i_Rx_DV   = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] bytes, input int n);
    logic [63:0] v;
    v = bytes;
    for (int i = 0; i < n; i++) begin
      send_byte(v[63:56]);
      v = v << 8;
    end
  endtask

  task automatic wait_evt(input int bd, input int be, input int lim);
    int t;
    t = 0;
    while ((done_n == bd) && (err_n == be) && (t < lim)) begin
      @(negedge i_Clock);
      t++;
    end
    repeat (2) @(posedge i_Clock);
    #1;
  endtask

  function automatic logic [31:0] outs_now();
    return {16'h0, bus.o_Wr_En, bus.o_Pkt_Done, bus.o_Pkt_Err, bus.o_Busy, 2'b00,
            bus.o_Err_Code, bus.o_Wr_Addr};
  endfunction

`ifdef UART_PKT_CHKSUM_EN
  localparam int NV = 6;
`else
  localparam int NV = 6;
`endif
  vec_t vecs [NV];

  initial begin
    int bw, bd, be, k_err;
    logic busy_8698, busy_8700;
    logic [47:0] w;

`ifdef UART_PKT_CHKSUM_EN
    vecs[0] = '{64'hA510_0211_2245_0000, 6, 2, 48'h1011_1122_0000, 1, 0, 2'b00};
    vecs[1] = '{64'hA510_0211_2246_0000, 6, 0, 48'h0,              0, 1, 2'b10};
    vecs[2] = '{64'hA500_0000_0000_0000, 3, 0, 48'h0,              0, 1, 2'b01};
    vecs[3] = '{64'hA500_1100_0000_0000, 3, 0, 48'h0,              0, 1, 2'b01};
    vecs[4] = '{64'h3344_A520_017E_9F00, 7, 1, 48'h207E_0000_0000, 1, 0, 2'b00};
    vecs[5] = '{64'hA5FE_0301_0203_0700, 7, 3, 48'hFE01_FF02_0003, 1, 0, 2'b00};
`else
    vecs[0] = '{64'hA510_0211_2200_0000, 5, 2, 48'h1011_1122_0000, 1, 0, 2'b00};
    vecs[1] = '{64'hA580_015A_0000_0000, 4, 1, 48'h805A_0000_0000, 1, 0, 2'b00};
    vecs[2] = '{64'hA500_0000_0000_0000, 3, 0, 48'h0,              0, 1, 2'b01};
    vecs[3] = '{64'hA500_1100_0000_0000, 3, 0, 48'h0,              0, 1, 2'b01};
    vecs[4] = '{64'h3344_A520_017E_0000, 6, 1, 48'h207E_0000_0000, 1, 0, 2'b00};
    vecs[5] = '{64'hA5FE_0301_0203_0000, 6, 3, 48'hFE01_FF02_0003, 1, 0, 2'b00};
`endif

    i_Rst_L       = 1'b0;
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    bus.i_Wr_Rdy  = 1'b1;
    #3;
    chk("reset_outputs", outs_now(), 32'h0);
    chk("reset_wr_data", 32'(bus.o_Wr_Data), 32'h0);
    #20;
    i_Rst_L = 1'b1;
    @(posedge i_Clock);
    #1;

    for (int v = 0; v < NV; v++) begin
      bw = wr_log.size();
      bd = done_n;
      be = err_n;
      send_frame(vecs[v].bytes, vecs[v].n);
      wait_evt(bd, be, 50);
      chk($sformatf("v%0d_nwr", v), 32'(wr_log.size() - bw), 32'(vecs[v].nwr));
      chk($sformatf("v%0d_done", v), 32'(done_n - bd), 32'(vecs[v].ndone));
      chk($sformatf("v%0d_err", v), 32'(err_n - be), 32'(vecs[v].nerr));
      if (vecs[v].nerr > 0) chk($sformatf("v%0d_code", v), 32'(last_code), 32'(vecs[v].code));
      w = vecs[v].wr;
      for (int i = 0; i < vecs[v].nwr && (bw + i) < wr_log.size(); i++) begin
        chk($sformatf("v%0d_w%0d", v, i), 32'(wr_log[bw + i][15:0]), 32'(w[47:32]));
        chk($sformatf("v%0d_w%0d_cyc", v, i), 32'(wr_log[bw + i][31:16]),
            32'(last_dv_cyc + 1 + i));
        w = w << 16;
      end
    end

    // Stalled first write at the 0xFF -> 0x00 address wrap.
    bw = wr_log.size();
    bd = done_n;
    bus.i_Wr_Rdy = 1'b0;
`ifdef UART_PKT_CHKSUM_EN
    send_frame(64'hA5FF_0201_0204_0000, 6);
`else
    send_frame(64'hA5FF_0201_0200_0000, 5);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge i_Clock);
      chk($sformatf("stall_hold%0d", i),
          {15'h0, bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data}, 32'h0001_FF01);
      @(posedge i_Clock);
      #1;
    end
    bus.i_Wr_Rdy = 1'b1;
    wait_evt(bd, err_n, 30);
    chk("stall_nwr", 32'(wr_log.size() - bw), 32'd2);
    if (wr_log.size() >= bw + 2) begin
      chk("stall_w0", 32'(wr_log[bw][15:0]), 32'h0000_FF01);
      chk("stall_w1", 32'(wr_log[bw + 1][15:0]), 32'h0000_0002);
    end
    chk("stall_done", 32'(done_n - bd), 32'd1);

    // Stray byte while the drain is stalled.
    bw = wr_log.size();
    bd = done_n;
    be = err_n;
    bus.i_Wr_Rdy = 1'b0;
`ifdef UART_PKT_CHKSUM_EN
    send_frame(64'hA510_0211_2245_0000, 6);
`else
    send_frame(64'hA510_0211_2200_0000, 5);
`endif
    send_byte(8'h5A);
    @(negedge i_Clock);
    chk("ovr_pulse", {29'h0, bus.o_Pkt_Err, bus.o_Err_Code}, 32'h7);
    chk("ovr_wr_en_held", 32'(bus.o_Wr_En), 32'd1);
    @(posedge i_Clock);
    #1;
    bus.i_Wr_Rdy = 1'b1;
    wait_evt(bd, be + 1, 30);
    chk("ovr_nwr", 32'(wr_log.size() - bw), 32'd2);
    chk("ovr_done", 32'(done_n - bd), 32'd1);
    chk("ovr_err", 32'(err_n - be), 32'd1);

    // Stray byte on the final-handshake cycle.
    bw = wr_log.size();
    bd = done_n;
    be = err_n;
`ifdef UART_PKT_CHKSUM_EN
    send_frame(64'hA540_0199_DA00_0000, 5);
`else
    send_frame(64'hA540_0199_0000_0000, 4);
`endif
    send_byte(8'h77);
    repeat (5) @(posedge i_Clock);
    #1;
    chk("fin_ovr_nwr", 32'(wr_log.size() - bw), 32'd1);
    if (wr_log.size() > bw) chk("fin_ovr_w0", 32'(wr_log[bw][15:0]), 32'h0000_4099);
    chk("fin_ovr_done", 32'(done_n - bd), 32'd1);
    chk("fin_ovr_err", 32'(err_n - be), 32'd1);
    chk("fin_ovr_code", 32'(last_code), 32'd3);

    // Reset in the middle of the payload abandons the packet.
    bw = wr_log.size();
    bd = done_n;
    be = err_n;
    send_frame(64'hA510_0311_0000_0000, 4);
    i_Rst_L = 1'b0;
    #1;
    chk("midrst_async", outs_now(), 32'h0);
    @(posedge i_Clock);
    #1;
    i_Rst_L = 1'b1;
`ifdef UART_PKT_CHKSUM_EN
    send_frame(64'h2233_7900_0000_0000, 3);
`else
    send_frame(64'h2233_0000_0000_0000, 2);
`endif
    repeat (5) @(posedge i_Clock);
    #1;
    chk("midrst_nwr", 32'(wr_log.size() - bw), 32'd0);
    chk("midrst_evts", 32'((done_n - bd) + (err_n - be)), 32'd0);
    chk("midrst_busy", 32'(bus.o_Busy), 32'd0);

    // LEN equal to MAX_LEN is accepted.
    bw = wr_log.size();
    bd = done_n;
    send_frame(64'hA530_1000_0000_0000, 3);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
`ifdef UART_PKT_CHKSUM_EN
    send_byte(8'hB8);
`endif
    wait_evt(bd, err_n, 60);
    chk("maxlen_nwr", 32'(wr_log.size() - bw), 32'd16);
    for (int i = 0; i < 16 && (bw + i) < wr_log.size(); i++) begin
      chk($sformatf("maxlen_w%0d", i), 32'(wr_log[bw + i][15:0]), {16'h0, 8'(8'h30 + i), 8'(i)});
    end
    chk("maxlen_done", 32'(done_n - bd), 32'd1);

    // Inter-byte timeout.
    be = err_n;
    k_err = -1;
    busy_8698 = 1'b0;
    busy_8700 = 1'b1;
    send_frame(64'hA510_0000_0000_0000, 2);
    for (int k = 0; k <= 8700; k++) begin
      @(negedge i_Clock);
      if (bus.o_Pkt_Err && k_err < 0) k_err = k;
      if (k == 8698) busy_8698 = bus.o_Busy;
      if (k == 8700) busy_8700 = bus.o_Busy;
    end
    @(posedge i_Clock);
    #1;
    chk("tmo_cycle", 32'(k_err), 32'd8699);
    chk("tmo_code", 32'(last_code), 32'd0);
    chk("tmo_err_cnt", 32'(err_n - be), 32'd1);
    chk("tmo_busy_before", 32'(busy_8698), 32'd1);
    chk("tmo_busy_after", 32'(busy_8700), 32'd0);

    // Byte landing exactly on the timeout cycle is consumed.
    bw = wr_log.size();
    bd = done_n;
    be = err_n;
    send_frame(64'hA510_0000_0000_0000, 2);
    repeat (8698) @(posedge i_Clock);
    #1;
`ifdef UART_PKT_CHKSUM_EN
    send_frame(64'h0211_2245_0000_0000, 4);
`else
    send_frame(64'h0211_2200_0000_0000, 3);
`endif
    wait_evt(bd, be, 30);
    chk("tmo_edge_err", 32'(err_n - be), 32'd0);
    chk("tmo_edge_done", 32'(done_n - bd), 32'd1);
    chk("tmo_edge_nwr", 32'(wr_log.size() - bw), 32'd2);

    chk("done_err_exclusive", 32'(both_n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
